flow_table_ctrl: RTL

Single-port owner and arbiter for the flow-table BRAM. It assembles CPU flow-entry writes, arriving as KEY_WORDS sequential 32-bit writes to the DATA register (offset 0xC), into one wide entry. It commits that entry to a programmable index while sharing the BRAM port with datapath lookups. Lookups have priority; a starvation guard bounds how long a pending CPU commit waits.

---
 rtl/flow_table_pkg.sv | 46 ++++
 rtl/flow_entry_stager.sv | 67 ++++++
 rtl/flow_table_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/flow_table_pkg.sv
// Shared definitions for the flow-table controller: register map, CTRL/STATUS
// field positions, FSM state type and default geometry.
package flow_table_pkg;

    localparam int KEY_WORDS_DEF    = 5;
    localparam int ADDR_W_DEF       = 10;
    localparam int STARVE_LIMIT_DEF = 8;

    localparam logic [3:0] REG_CTRL   = 4'h0;
    localparam logic [3:0] REG_INDEX  = 4'h4;
    localparam logic [3:0] REG_STATUS = 4'h8;
    localparam logic [3:0] REG_DATA   = 4'hC;

    localparam int CTRL_ABORT_BIT   = 0;
    localparam int CTRL_CLR_OVR_BIT = 1;

    localparam int ST_PENDING_BIT = 0;
    localparam int ST_WCNT_LSB    = 1;
    localparam int ST_WCNT_MSB    = 3;
    localparam int ST_OVERRUN_BIT = 4;
    localparam int ST_COMMIT_LSB  = 16;
    localparam int ST_COMMIT_MSB  = 31;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PENDING = 2'd2
    } ft_state_e;

    // Assemble the read-only STATUS word from its fields.
    function automatic logic [31:0] pack_status(
        input logic        pending,
        input logic [2:0]  wcnt,
        input logic        overrun,
        input logic [15:0] commits
    );
        logic [31:0] s;
        s = 32'h0000_0000;
        s[ST_PENDING_BIT]              = pending;
        s[ST_WCNT_MSB:ST_WCNT_LSB]     = wcnt;
        s[ST_OVERRUN_BIT]              = overrun;
        s[ST_COMMIT_MSB:ST_COMMIT_LSB] = commits;
        return s;
    endfunction

endpackage

// File: rtl/flow_entry_stager.sv
// Collects sequential 32-bit CPU words into one wide flow entry (word 0 in the
// LSBs) and keeps the sticky overrun flag for words that arrive while a full
// entry is still waiting for the BRAM port.
module flow_entry_stager
    import flow_table_pkg::*;
#(
    parameter int KEY_WORDS = KEY_WORDS_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    word_en,
    input  logic [31:0]             word_data,
    input  logic                    abort,
    input  logic                    set_overrun,
    input  logic                    clr_overrun,
    output logic [2:0]              word_cnt_r,
    output logic                    entry_done_s,
    output logic [32*KEY_WORDS-1:0] staging_r,
    output logic                    overrun_r
);

    localparam logic [2:0] LAST_IDX = 3'(KEY_WORDS - 1);

    assign entry_done_s = word_en && (word_cnt_r == LAST_IDX);

    // Word counter: wraps to zero when the last word of an entry lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt_r <= 3'd0;
        end else if (abort) begin
            word_cnt_r <= 3'd0;
        end else if (entry_done_s) begin
            word_cnt_r <= 3'd0;
        end else if (word_en) begin
            word_cnt_r <= word_cnt_r + 3'd1;
        end else begin
            word_cnt_r <= word_cnt_r;
        end
    end

    // Staging register: each accepted word fills the slot named by word_cnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staging_r <= '0;
        end else begin
            for (int k = 0; k < KEY_WORDS; k++) begin
                if (word_en && (word_cnt_r == 3'(k))) begin
                    staging_r[32*k +: 32] <= word_data;
                end
            end
        end
    end

    // Sticky overrun flag, cleared only by an explicit CTRL request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_r <= 1'b0;
        end else if (clr_overrun) begin
            overrun_r <= 1'b0;
        end else if (set_overrun) begin
            overrun_r <= 1'b1;
        end else begin
            overrun_r <= overrun_r;
        end
    end

endmodule

// File: rtl/flow_table_ctrl.sv
// Flow-table BRAM owner: decodes the CPU register window, stages flow entries,
// and arbitrates the single BRAM port between lookups (priority) and CPU
// commits, with a starvation guard bounding how long a commit can wait.
module flow_table_ctrl
    import flow_table_pkg::*;
#(
    parameter  int KEY_WORDS    = KEY_WORDS_DEF,
    parameter  int ADDR_W       = ADDR_W_DEF,
    parameter  int STARVE_LIMIT = STARVE_LIMIT_DEF,
    localparam int EW           = 32 * KEY_WORDS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_wr_en,
    input  logic [3:0]        cfg_wr_addr,
    input  logic [31:0]       cfg_wr_data,
    input  logic [3:0]        cfg_rd_addr,
    output logic [31:0]       cfg_rd_data,
    input  logic              lk_req_valid,
    output logic              lk_req_ready,
    input  logic [ADDR_W-1:0] lk_req_addr,
    output logic              lk_rsp_valid,
    output logic [EW-1:0]     lk_rsp_data,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [EW-1:0]     bram_wdata,
    input  logic [EW-1:0]     bram_rdata
);

    localparam int              SW         = $clog2(STARVE_LIMIT + 2);
    localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);

    ft_state_e          state_r;
    ft_state_e          state_nxt_s;
    logic [SW-1:0]      starve_cnt_r;
    logic [ADDR_W-1:0]  index_r;
    logic [15:0]        commit_cnt_r;
    logic               lk_rsp_valid_r;

    logic               data_wr_s;
    logic               index_wr_s;
    logic               ctrl_wr_s;
    logic               grant_wr_s;
    logic               word_en_s;
    logic               set_overrun_s;
    logic               clr_overrun_s;
    logic               abort_s;

    logic [2:0]         word_cnt_s;
    logic               entry_done_s;
    logic [EW-1:0]      staging_s;
    logic               overrun_s;

    assign data_wr_s  = cfg_wr_en && (cfg_wr_addr == REG_DATA);
    assign index_wr_s = cfg_wr_en && (cfg_wr_addr == REG_INDEX);
    assign ctrl_wr_s  = cfg_wr_en && (cfg_wr_addr == REG_CTRL);

    // A pending commit takes the port when nobody is looking up, or once it
    // has lost STARVE_LIMIT consecutive cycles.
    assign grant_wr_s = (state_r == ST_PENDING) &&
                        (!lk_req_valid || (starve_cnt_r == STARVE_MAX));

    // A word written in the grant cycle already belongs to the next entry.
    assign word_en_s     = data_wr_s && ((state_r != ST_PENDING) || grant_wr_s);
    assign set_overrun_s = data_wr_s && (state_r == ST_PENDING) && !grant_wr_s;
    assign clr_overrun_s = ctrl_wr_s && cfg_wr_data[CTRL_CLR_OVR_BIT];
    // The commit beats an abort issued in the same cycle.
    assign abort_s       = ctrl_wr_s && cfg_wr_data[CTRL_ABORT_BIT] && !grant_wr_s;

    flow_entry_stager #(
        .KEY_WORDS (KEY_WORDS)
    ) u_stager (
        .clk          (clk),
        .rst_n        (rst_n),
        .word_en      (word_en_s),
        .word_data    (cfg_wr_data),
        .abort        (abort_s),
        .set_overrun  (set_overrun_s),
        .clr_overrun  (clr_overrun_s),
        .word_cnt_r   (word_cnt_s),
        .entry_done_s (entry_done_s),
        .staging_r    (staging_s),
        .overrun_r    (overrun_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic and BRAM port / lookup-ready drive.
    always_comb begin
        state_nxt_s  = state_r;
        lk_req_ready = 1'b1;
        bram_en      = 1'b0;
        bram_we      = 1'b0;
        bram_addr    = '0;
        bram_wdata   = '0;

        if (grant_wr_s) begin
            lk_req_ready = 1'b0;
            bram_en      = 1'b1;
            bram_we      = 1'b1;
            bram_addr    = index_r;
            bram_wdata   = staging_s;
        end else if (lk_req_valid) begin
            bram_en      = 1'b1;
            bram_addr    = lk_req_addr;
        end else begin
            bram_en      = 1'b0;
        end

        case (state_r)
            ST_IDLE: begin
                if (word_en_s) begin
                    state_nxt_s = entry_done_s ? ST_PENDING : ST_COLLECT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (abort_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (entry_done_s) begin
                    state_nxt_s = ST_PENDING;
                end else begin
                    state_nxt_s = ST_COLLECT;
                end
            end
            ST_PENDING: begin
                if (grant_wr_s) begin
                    if (word_en_s) begin
                        state_nxt_s = entry_done_s ? ST_PENDING : ST_COLLECT;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else if (abort_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_PENDING;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Starvation counter: counts lookups that beat a pending commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_r <= '0;
        end else if (grant_wr_s || abort_s) begin
            starve_cnt_r <= '0;
        end else if ((state_r == ST_PENDING) && lk_req_valid && (starve_cnt_r != STARVE_MAX)) begin
            starve_cnt_r <= starve_cnt_r + SW'(1);
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    // Commit index: CPU-programmable, auto-increments after every commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_r <= '0;
        end else if (index_wr_s) begin
            index_r <= cfg_wr_data[ADDR_W-1:0];
        end else if (grant_wr_s) begin
            index_r <= index_r + ADDR_W'(1);
        end else begin
            index_r <= index_r;
        end
    end

    // Commit counter (wraps at 16 bits).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_cnt_r <= 16'd0;
        end else if (grant_wr_s) begin
            commit_cnt_r <= commit_cnt_r + 16'd1;
        end else begin
            commit_cnt_r <= commit_cnt_r;
        end
    end

    // Lookup response valid follows an accepted request by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lk_rsp_valid_r <= 1'b0;
        end else begin
            lk_rsp_valid_r <= lk_req_valid && lk_req_ready;
        end
    end

    assign lk_rsp_valid = lk_rsp_valid_r;
    assign lk_rsp_data  = lk_rsp_valid_r ? bram_rdata : '0;

    // Register read mux; CTRL and DATA are write-only and read as zero.
    always_comb begin
        cfg_rd_data = 32'h0000_0000;
        case (cfg_rd_addr)
            REG_INDEX:  cfg_rd_data = {{(32-ADDR_W){1'b0}}, index_r};
            REG_STATUS: cfg_rd_data = pack_status(state_r == ST_PENDING, word_cnt_s,
                                                  overrun_s, commit_cnt_r);
            REG_CTRL:   cfg_rd_data = 32'h0000_0000;
            REG_DATA:   cfg_rd_data = 32'h0000_0000;
            default:    cfg_rd_data = 32'h0000_0000;
        endcase
    end

endmodule
